// File: rtl/qdec_pkg.sv
// rtl/qdec_pkg.sv - quadrature state encodings, step codes and the transition classifier.
package qdec_pkg;

  localparam logic [1:0] QS_00 = 2'b00;
  localparam logic [1:0] QS_01 = 2'b01;
  localparam logic [1:0] QS_11 = 2'b11;
  localparam logic [1:0] QS_10 = 2'b10;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_FWD  = 2'd1,
    STEP_REV  = 2'd2,
    STEP_ILL  = 2'd3
  } step_t;

  // State is {A,B}; clockwise walks 00->01->11->10->00.
  function automatic step_t next_step(input logic [1:0] prev, input logic [1:0] cur);
    step_t s;
    case ({prev, cur})
      {QS_00, QS_01}, {QS_01, QS_11}, {QS_11, QS_10}, {QS_10, QS_00}: s = STEP_FWD;
      {QS_01, QS_00}, {QS_11, QS_01}, {QS_10, QS_11}, {QS_00, QS_10}: s = STEP_REV;
      default: s = (prev == cur) ? STEP_NONE : STEP_ILL;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/qdec_debounce.sv
// rtl/qdec_debounce.sv - synchroniser plus stable-level debounce filter for one encoder channel.
module qdec_debounce #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_filt
);

  localparam int CNT_W = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_filt;
  logic                   w_synced;

  assign w_synced = r_sync[SYNC_STAGES-1];
  assign o_filt   = r_filt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
    end
  end

  // A new level is accepted only after DEB_CYCLES consecutive differing clocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_filt <= 1'b1;
    end else if (w_synced == r_filt) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_filt <= w_synced;
      r_cnt  <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/quad_step_decoder.sv
// rtl/quad_step_decoder.sv - debounced quadrature decoder emitting one left/right pulse per detent.
// Optional sticky illegal-transition flag and counter when QDEC_ERR_EN is defined.
module quad_step_decoder
  import qdec_pkg::*;
#(
  parameter int SYNC_STAGES      = 2,
  parameter int DEB_CYCLES       = 50000,
  parameter int STEPS_PER_DETENT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a,
  input  logic       b,
`ifdef QDEC_ERR_EN
  input  logic       err_clr,
  output logic       err,
  output logic [7:0] err_cnt,
`endif
  output logic       left,
  output logic       right
);

  localparam int ACC_W = $clog2(STEPS_PER_DETENT) + 2;
  localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(STEPS_PER_DETENT - 1);
  localparam logic signed [ACC_W-1:0] ACC_MIN = -ACC_MAX;
  localparam logic signed [ACC_W-1:0] ACC_ONE = ACC_W'(1);

  logic                    w_filt_a;
  logic                    w_filt_b;
  logic [1:0]              w_cur;
  step_t                   w_step;
  logic [1:0]              r_prev;
  logic signed [ACC_W-1:0] r_acc;
  logic                    r_left;
  logic                    r_right;

  qdec_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEB_CYCLES(DEB_CYCLES)) u_deb_a (
    .clk(clk), .rst(rst), .i_raw(a), .o_filt(w_filt_a)
  );

  qdec_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEB_CYCLES(DEB_CYCLES)) u_deb_b (
    .clk(clk), .rst(rst), .i_raw(b), .o_filt(w_filt_b)
  );

  assign w_cur  = {w_filt_a, w_filt_b};
  assign w_step = next_step(r_prev, w_cur);
  assign left   = r_left;
  assign right  = r_right;

  // Pulse on the step that completes a detent; landing on 11 otherwise re-zeros the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev  <= QS_11;
      r_acc   <= '0;
      r_left  <= 1'b0;
      r_right <= 1'b0;
    end else begin
      r_prev  <= w_cur;
      r_left  <= 1'b0;
      r_right <= 1'b0;
      case (w_step)
        STEP_FWD: begin
          if (r_acc == ACC_MAX) begin
            r_right <= 1'b1;
            r_acc   <= '0;
          end else if (w_cur == QS_11) begin
            r_acc <= '0;
          end else begin
            r_acc <= r_acc + ACC_ONE;
          end
        end
        STEP_REV: begin
          if (r_acc == ACC_MIN) begin
            r_left <= 1'b1;
            r_acc  <= '0;
          end else if (w_cur == QS_11) begin
            r_acc <= '0;
          end else begin
            r_acc <= r_acc - ACC_ONE;
          end
        end
        STEP_ILL: r_acc <= '0;
        default:  ;
      endcase
    end
  end

`ifdef QDEC_ERR_EN
  logic       r_err;
  logic [7:0] r_err_cnt;

  assign err     = r_err;
  assign err_cnt = r_err_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err     <= 1'b0;
      r_err_cnt <= 8'd0;
    end else if (err_clr) begin
      r_err     <= 1'b0;
      r_err_cnt <= 8'd0;
    end else if (w_step == STEP_ILL) begin
      r_err <= 1'b1;
      if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_quad_step_decoder.sv
// tb/tb_quad_step_decoder.sv - directed table and sequence bench for quad_step_decoder.
module tb_quad_step_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a   = 1'b1;
  logic b   = 1'b1;
  logic left;
  logic right;
`ifdef QDEC_ERR_EN
  logic       err_clr = 1'b0;
  logic       err;
  logic [7:0] err_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int r_seen = 0;
  int l_seen = 0;
  int viol   = 0;
  logic last_pulse = 1'b0;

  always #5 clk = ~clk;

  quad_step_decoder #(.SYNC_STAGES(2), .DEB_CYCLES(4), .STEPS_PER_DETENT(4)) dut (
    .clk(clk),
    .rst(rst),
    .a(a),
    .b(b),
`ifdef QDEC_ERR_EN
    .err_clr(err_clr),
    .err(err),
    .err_cnt(err_cnt),
`endif
    .left(left),
    .right(right)
  );

  always @(negedge clk) begin
    if (!rst) begin
      if (right) r_seen++;
      if (left) l_seen++;
      if (left && right) viol++;
      if ((left || right) && last_pulse) viol++;
      last_pulse = left | right;
    end else begin
      last_pulse = 1'b0;
    end
  end

  typedef struct {
    string      name;
    logic [9:0] lv;
    int         exp_r;
    int         exp_l;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] ab, input int hold);
    @(negedge clk);
    a = ab[1];
    b = ab[0];
    repeat (hold) @(negedge clk);
  endtask

  task automatic run_seq(input logic [9:0] lv);
    for (int i = 4; i >= 0; i--) begin
      drive(lv[i*2 +: 2], 10);
    end
    repeat (10) @(negedge clk);
  endtask

  initial begin
    int r0, l0, first;
    vecs[0] = '{"cw_full",     10'b11_10_00_01_11, 1, 0};
    vecs[1] = '{"ccw_full",    10'b11_01_00_10_11, 0, 1};
    vecs[2] = '{"cw_two_back", 10'b11_10_00_10_11, 0, 0};
    vecs[3] = '{"cw_after",    10'b11_10_00_01_11, 1, 0};
    vecs[4] = '{"ccw_half",    10'b11_01_00_01_11, 0, 0};

    #12;
    check("reset_left", int'(left), 0);
    check("reset_right", int'(right), 0);
`ifdef QDEC_ERR_EN
    check("reset_err", int'(err), 0);
    check("reset_err_cnt", int'(err_cnt), 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      r0 = r_seen;
      l0 = l_seen;
      run_seq(vecs[v].lv);
      check({vecs[v].name, "_right"}, r_seen - r0, vecs[v].exp_r);
      check({vecs[v].name, "_left"}, l_seen - l0, vecs[v].exp_l);
    end

    // Glitch on A shorter than the debounce window.
    r0 = r_seen;
    l0 = l_seen;
    drive(2'b01, 2);
    drive(2'b11, 15);
    check("glitch_right", r_seen - r0, 0);
    check("glitch_left", l_seen - l0, 0);

    // Latency of the last edge of a CW detent to the right pulse.
    drive(2'b10, 10);
    drive(2'b00, 10);
    drive(2'b01, 10);
    @(negedge clk);
    a = 1'b1;
    b = 1'b1;
    first = -1;
    r0 = r_seen;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (right && first < 0) first = k;
    end
    check("latency_cycle", first, 7);
    check("latency_width", r_seen - r0, 1);

    // Both lines flip in one clock.
    r0 = r_seen;
    l0 = l_seen;
    drive(2'b00, 10);
    check("illegal_pulses", (r_seen - r0) + (l_seen - l0), 0);
`ifdef QDEC_ERR_EN
    check("illegal_err", int'(err), 1);
    check("illegal_err_cnt", int'(err_cnt), 1);
`endif
    drive(2'b01, 10);
    drive(2'b11, 10);
    check("illegal_recover_pulses", (r_seen - r0) + (l_seen - l0), 0);
`ifdef QDEC_ERR_EN
    check("err_sticky", int'(err), 1);
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("err_clr_err", int'(err), 0);
    check("err_clr_cnt", int'(err_cnt), 0);
`endif

    // Reset mid-detent with the lines parked at 00.
    drive(2'b10, 10);
    drive(2'b00, 10);
    #3;
    rst = 1'b1;
    #1;
    check("midrst_left", int'(left), 0);
    check("midrst_right", int'(right), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    r0 = r_seen;
    l0 = l_seen;
    repeat (10) @(negedge clk);
`ifdef QDEC_ERR_EN
    check("midrst_err_cnt", int'(err_cnt), 1);
`endif
    drive(2'b01, 10);
    drive(2'b11, 10);
    check("midrst_settle_pulses", (r_seen - r0) + (l_seen - l0), 0);
    run_seq(10'b11_10_00_01_11);
    check("midrst_cw_right", r_seen - r0, 1);
    check("midrst_cw_left", l_seen - l0, 0);

    check("pulse_rule_violations", viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
